dsp_sum_controller: RTL

Sequencer that drives the DSP equation-sum datapath from memory. On a software start it reads a block of `dsp_input2_reg` words over a Wishbone master port, starting at a base address. It accumulates the words into a 2*dw-bit sum and writes the result back to a destination address. It then raises an interrupt. It sits between the DSP register file (dsp_input*/dsp_output* registers) and the system Wishbone bus.

---
 rtl/dsp_sum_controller.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/dsp_sum_controller.sv
// Wishbone sequencer for the DSP equation-sum block. It reads a block of words,
// accumulates them into a 2*dw-bit sum, writes the sum back, then raises an interrupt.
module dsp_sum_controller #(
    parameter int dw      = 32,
    parameter int aw      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic [dw-1:0] dsp_input0_reg,
    input  logic [dw-1:0] dsp_input1_reg,
    input  logic [dw-1:0] dsp_input2_reg,
    input  logic [dw-1:0] dsp_input3_reg,
    output logic [dw-1:0] dsp_output0_reg,
    output logic [dw-1:0] dsp_output1_reg,
    output logic [dw-1:0] dsp_output2_reg,
    output logic [dw-1:0] dsp_output3_reg,
    output logic [aw-1:0] wbm_adr_o,
    output logic [dw-1:0] wbm_dat_o,
    input  logic [dw-1:0] wbm_dat_i,
    output logic [3:0]    wbm_sel_o,
    output logic          wbm_we_o,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    input  logic          wbm_ack_i,
    input  logic          wbm_err_i,
    output logic          interrupt,
    output logic          error
);

    localparam int SW = 2 * dw;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WR_LO,
        S_WR_HI,
        S_DONE,
        S_ERROR
    } state_t;

    state_t         r_state;
    state_t         w_nextState;
    logic           r_startPrev;
    logic [aw-1:0]  r_src;
    logic [aw-1:0]  r_dst;
    logic [15:0]    r_len;
    logic [15:0]    r_count;
    logic [15:0]    r_timer;
    logic [SW-1:0]  r_sum;
    logic           r_busy;
    logic           r_done;
    logic           r_busErr;
    logic           r_timeoutFlag;
    logic           r_irq;
    logic           r_error;

    logic           w_busState;
    logic           w_start;
    logic           w_ack;
    logic           w_err;
    logic           w_timeout;
    logic           w_lastRead;
    logic [15:0]    w_newLen;
    logic           w_unused;

    assign w_unused   = ^{dsp_input0_reg[dw-1:2], dsp_input2_reg[dw-1:16]};
    assign w_newLen   = dsp_input2_reg[15:0];
    assign w_busState = (r_state == S_READ) || (r_state == S_WR_LO) || (r_state == S_WR_HI);
    // ERROR behaves like DONE as far as restarting is concerned.
    assign w_start    = dsp_input0_reg[0] && !r_startPrev &&
                        ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
    assign w_err      = w_busState && wbm_err_i;
    assign w_ack      = w_busState && wbm_ack_i && !wbm_err_i;
    assign w_timeout  = w_busState && !wbm_ack_i && !wbm_err_i && (r_timer == 16'(TIMEOUT - 1));
    assign w_lastRead = (r_count + 16'd1) == r_len;

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) r_state <= S_IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        wbm_cyc_o   = 1'b0;
        wbm_stb_o   = 1'b0;
        wbm_we_o    = 1'b0;
        wbm_adr_o   = '0;
        wbm_dat_o   = '0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (w_start)                  w_nextState = (w_newLen == 16'd0) ? S_DONE : S_READ;
                else if (r_state == S_ERROR)  w_nextState = S_IDLE;
            end
            S_READ: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_adr_o = r_src + aw'({r_count, 2'b00});
                if (w_err || w_timeout)       w_nextState = S_ERROR;
                else if (w_ack && w_lastRead) w_nextState = S_WR_LO;
            end
            S_WR_LO: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_we_o  = 1'b1;
                wbm_adr_o = r_dst;
                wbm_dat_o = r_sum[dw-1:0];
                if (w_err || w_timeout)       w_nextState = S_ERROR;
                else if (w_ack)               w_nextState = S_WR_HI;
            end
            S_WR_HI: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_we_o  = 1'b1;
                wbm_adr_o = r_dst + aw'(4);
                wbm_dat_o = r_sum[SW-1:dw];
                if (w_err || w_timeout)       w_nextState = S_ERROR;
                else if (w_ack)               w_nextState = S_DONE;
            end
            default: w_nextState = S_IDLE;
        endcase
        wbm_sel_o = wbm_cyc_o ? 4'hF : 4'h0;
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_startPrev   <= 1'b0;
            r_src         <= '0;
            r_dst         <= '0;
            r_len         <= '0;
            r_count       <= '0;
            r_timer       <= '0;
            r_sum         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_busErr      <= 1'b0;
            r_timeoutFlag <= 1'b0;
            r_irq         <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_startPrev <= dsp_input0_reg[0];
            // The ack timer only runs while one transfer is waiting on the slave.
            if (!w_busState || w_ack || (w_nextState != r_state)) r_timer <= '0;
            else                                                   r_timer <= r_timer + 16'd1;

            if (w_start) begin
                r_src         <= aw'(dsp_input1_reg);
                r_dst         <= aw'(dsp_input3_reg);
                r_len         <= w_newLen;
                r_sum         <= '0;
                r_count       <= '0;
                r_busy        <= (w_newLen != 16'd0);
                r_done        <= (w_newLen == 16'd0);
                r_busErr      <= 1'b0;
                r_timeoutFlag <= 1'b0;
                r_error       <= 1'b0;
                r_irq         <= (w_newLen == 16'd0);
            end else begin
                if (dsp_input0_reg[1]) r_irq <= 1'b0;
                if ((r_state == S_READ) && w_ack) begin
                    r_sum   <= r_sum + SW'(wbm_dat_i);
                    r_count <= r_count + 16'd1;
                end
                // Completion events are applied last so a concurrent irq_clear cannot hide them.
                if (w_err) begin
                    r_busErr <= 1'b1;
                    r_error  <= 1'b1;
                    r_irq    <= 1'b1;
                    r_busy   <= 1'b0;
                end else if (w_timeout) begin
                    r_timeoutFlag <= 1'b1;
                    r_error       <= 1'b1;
                    r_irq         <= 1'b1;
                    r_busy        <= 1'b0;
                end else if ((r_state == S_WR_HI) && w_ack) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_irq  <= 1'b1;
                end
            end
        end
    end

    assign dsp_output0_reg = dw'({r_timeoutFlag, r_busErr, r_done, r_busy});
    assign dsp_output1_reg = r_sum[dw-1:0];
    assign dsp_output2_reg = r_sum[SW-1:dw];
    assign dsp_output3_reg = dw'(r_count);
    assign interrupt       = r_irq;
    assign error           = r_error;

endmodule
